xor_key_inject: RTL and testbench

- Parametrised successor of the single-shot end-of-permutation XOR stage.
- Applies the key and domain-separation XORs at every Ascon phase boundary: init end, finalization begin, finalization end/tag, and domain separation.
- Holds the key in an internal register and exposes the result through a one-deep registered valid/ready stage.
- On finalization end it also produces the 128-bit tag and a registered match flag.
- Sits between the permutation core and the FSM/datapath mux.

---
 rtl/xor_key_inject.sv | 140 ++++++++++++++
 tb/tb_xor_key_inject.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xor_key_inject.sv
// Phase-boundary key / domain-separation XOR stage for the Ascon permutation,
// with an internal key register, a one-deep valid/ready output register and tag compare.

package xor_key_inject_pkg;
  localparam int unsigned STATE_WORDS = 5;
  localparam int unsigned WORD_W      = 64;
  localparam int unsigned TAG_W       = 128;

  typedef logic [STATE_WORDS-1:0][WORD_W-1:0] type_state;

  typedef enum logic [1:0] {
    MODE_PASS        = 2'd0,
    MODE_INIT_END    = 2'd1,
    MODE_FINAL_BEGIN = 2'd2,
    MODE_FINAL_END   = 2'd3
  } mode_e;
endpackage

module xor_key_inject
  import xor_key_inject_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 128,
  parameter int unsigned RATE_WORDS = 1
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  input  logic                 key_load_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 key_valid_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           mode_i,
  input  logic                 dsep_i,
  input  type_state            state_i,
  input  logic [TAG_W-1:0]     tag_ref_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output type_state            state_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 tag_valid_o,
  output logic                 tag_match_o
);

  localparam int unsigned NW     = (KEY_WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned KEXT_W = NW * WORD_W;

  logic [KEY_WIDTH-1:0]        key_q;
  logic [KEXT_W-1:0]           key_ext;
  logic [NW-1:0][WORD_W-1:0]   key_chunk;
  type_state                   key_mask;
  type_state                   result_c;
  logic [TAG_W-1:0]            result_tag_c;
  logic                        key_en;
  int unsigned                 base;
  int unsigned                 n_chunks;
  int unsigned                 idx;
  logic                        key_block_c;
  logic                        xfer_c;
  logic [1:0]                  mode_q;
  logic                        match_q;

  assign key_ext   = KEXT_W'(key_q);
  assign key_chunk = key_ext;

  // Build the XOR mask: key chunks at the mode's base word plus the dsep bit in word 4.
  always_comb begin
    key_en   = 1'b0;
    base     = 0;
    n_chunks = 0;
    idx      = 0;
    key_mask = '0;
    unique case (mode_e'(mode_i))
      MODE_INIT_END: begin
        key_en   = 1'b1;
        base     = STATE_WORDS - NW;
        n_chunks = NW;
      end
      MODE_FINAL_BEGIN: begin
        key_en   = 1'b1;
        base     = RATE_WORDS;
        n_chunks = NW;
      end
      MODE_FINAL_END: begin
        key_en   = 1'b1;
        base     = 3;
        n_chunks = 2;
      end
      default: ;
    endcase
    for (int unsigned j = 0; j < NW; j++) begin
      idx = base + j;
      if (key_en && (j < n_chunks) && (idx < STATE_WORDS)) begin
        key_mask[idx[2:0]] = key_chunk[j];
      end
    end
    key_mask[4][63] = key_mask[4][63] ^ dsep_i;
  end

  assign result_c     = state_i ^ key_mask;
  assign result_tag_c = {result_c[4], result_c[3]};

  // Key modes stall until a key has been loaded.
  assign key_block_c = (mode_i != MODE_PASS) && !key_valid_o;
  assign in_ready_o  = (!out_valid_o || out_ready_i) && !key_block_c;
  assign xfer_c      = in_valid_i && in_ready_o;

  // Key register; a load takes effect for transfers from the next cycle on.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      key_q       <= '0;
      key_valid_o <= 1'b0;
    end else if (key_load_i) begin
      key_q       <= key_i;
      key_valid_o <= 1'b1;
    end
  end

  // One-deep output stage.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      out_valid_o <= 1'b0;
      state_o     <= '0;
      tag_o       <= '0;
      mode_q      <= 2'(MODE_PASS);
      match_q     <= 1'b0;
    end else if (xfer_c) begin
      out_valid_o <= 1'b1;
      state_o     <= result_c;
      tag_o       <= result_tag_c;
      mode_q      <= mode_i;
      match_q     <= (result_tag_c == tag_ref_i);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign tag_valid_o = out_valid_o && (mode_q == MODE_FINAL_END);
  assign tag_match_o = match_q && tag_valid_o;

endmodule

// File: tb/tb_xor_key_inject.sv
// Directed bench for xor_key_inject: three instances (128/rate1, 160/rate1, 128/rate2)
// share stimulus and are checked against hand-computed expected values.

module tb_xor_key_inject;
  import xor_key_inject_pkg::*;

  localparam logic [159:0] K1 = {32'hDEADBEEF, 128'h00112233445566778899AABBCCDDEEFF};
  localparam logic [159:0] K2 = {32'h0BADF00D, 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0};
  localparam logic [63:0]  DS = 64'h8000000000000000;
  localparam logic [63:0]  VA = 64'h0123456789ABCDEF;
  localparam logic [63:0]  VB = 64'hFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         key_load = 1'b0;
  logic [159:0] key_bus = '0;
  logic         in_valid = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         dsep = 1'b0;
  type_state    st_in = '0;
  logic [127:0] tag_ref = '0;
  logic         out_ready = 1'b0;

  logic         kv_a, kv_b, kv_c, ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic         tv_a, tv_b, tv_c, tm_a, tm_b, tm_c;
  type_state    so_a, so_b, so_c;
  logic [127:0] to_a, to_b, to_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_key_inject #(.KEY_WIDTH(128), .RATE_WORDS(1)) dut_a (
    .clock_i(clk), .resetb_i(resetb), .key_load_i(key_load), .key_i(key_bus[127:0]),
    .key_valid_o(kv_a), .in_valid_i(in_valid), .in_ready_o(ir_a), .mode_i(mode),
    .dsep_i(dsep), .state_i(st_in), .tag_ref_i(tag_ref), .out_valid_o(ov_a),
    .out_ready_i(out_ready), .state_o(so_a), .tag_o(to_a), .tag_valid_o(tv_a),
    .tag_match_o(tm_a));

  xor_key_inject #(.KEY_WIDTH(160), .RATE_WORDS(1)) dut_b (
    .clock_i(clk), .resetb_i(resetb), .key_load_i(key_load), .key_i(key_bus),
    .key_valid_o(kv_b), .in_valid_i(in_valid), .in_ready_o(ir_b), .mode_i(mode),
    .dsep_i(dsep), .state_i(st_in), .tag_ref_i(tag_ref), .out_valid_o(ov_b),
    .out_ready_i(out_ready), .state_o(so_b), .tag_o(to_b), .tag_valid_o(tv_b),
    .tag_match_o(tm_b));

  xor_key_inject #(.KEY_WIDTH(128), .RATE_WORDS(2)) dut_c (
    .clock_i(clk), .resetb_i(resetb), .key_load_i(key_load), .key_i(key_bus[127:0]),
    .key_valid_o(kv_c), .in_valid_i(in_valid), .in_ready_o(ir_c), .mode_i(mode),
    .dsep_i(dsep), .state_i(st_in), .tag_ref_i(tag_ref), .out_valid_o(ov_c),
    .out_ready_i(out_ready), .state_o(so_c), .tag_o(to_c), .tag_valid_o(tv_c),
    .tag_match_o(tm_c));

  function automatic type_state mk(input logic [63:0] w0, w1, w2, w3, w4);
    type_state s;
    s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3; s[4] = w4;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_out_valid", 320'(ov_a), 320'(0));
    chk("rst_state", so_a, 320'(0));
    chk("rst_tag", 320'(to_a), 320'(0));
    chk("rst_tag_valid", 320'(tv_a), 320'(0));
    chk("rst_tag_match", 320'(tm_a), 320'(0));
    chk("rst_key_valid", 320'({kv_a, kv_b, kv_c}), 320'(0));
    resetb = 1'b1;
    #1;

    // Key mode before any key load is blocked
    in_valid = 1'b1; mode = 2'd1; out_ready = 1'b1; st_in = '0;
    #1;
    chk("nokey_in_ready", 320'(ir_a), 320'(0));
    step();
    chk("nokey_no_xfer", 320'(ov_a), 320'(0));

    // PASS with words 1..5
    mode = 2'd0; st_in = mk(64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    #1;
    chk("pass_in_ready", 320'(ir_a), 320'(1));
    step();
    chk("pass_out_valid", 320'(ov_a), 320'(1));
    chk("pass_state", so_a, mk(64'd1, 64'd2, 64'd3, 64'd4, 64'd5));
    chk("pass_tag", 320'(to_a), 320'({64'd5, 64'd4}));
    chk("pass_tag_valid", 320'(tv_a), 320'(0));

    // Load key, no transfer: output drains
    in_valid = 1'b0; key_load = 1'b1; key_bus = K1;
    step();
    key_load = 1'b0;
    chk("key_valid", 320'({kv_a, kv_b, kv_c}), 320'(3'b111));
    chk("drain_out_valid", 320'(ov_a), 320'(0));

    // INIT_END on zero state
    in_valid = 1'b1; mode = 2'd1; st_in = '0;
    step();
    chk("init_128", so_a, mk(64'd0, 64'd0, 64'd0, K1[63:0], K1[127:64]));
    chk("init_160", so_b, mk(64'd0, 64'd0, K1[63:0], K1[127:64], {32'd0, K1[159:128]}));
    chk("init_128a", so_c, mk(64'd0, 64'd0, 64'd0, K1[63:0], K1[127:64]));

    // FINAL_BEGIN with dsep on zero state
    mode = 2'd2; dsep = 1'b1;
    step();
    chk("fbeg_128", so_a, mk(64'd0, K1[63:0], K1[127:64], 64'd0, DS));
    chk("fbeg_160", so_b, mk(64'd0, K1[63:0], K1[127:64], {32'd0, K1[159:128]}, DS));
    chk("fbeg_128a", so_c, mk(64'd0, 64'd0, K1[63:0], K1[127:64], DS));
    chk("fbeg_tag_valid", 320'(tv_a), 320'(0));

    // FINAL_END with matching tag reference
    mode = 2'd3; dsep = 1'b0;
    st_in = mk(64'h11, 64'h22, 64'h33, VA, VB);
    tag_ref = {VB ^ K1[127:64], VA ^ K1[63:0]};
    step();
    chk("fend_state", so_a, mk(64'h11, 64'h22, 64'h33, VA ^ K1[63:0], VB ^ K1[127:64]));
    chk("fend_tag", 320'(to_a), 320'({VB ^ K1[127:64], VA ^ K1[63:0]}));
    chk("fend_tag_valid", 320'({tv_a, tv_b, tv_c}), 320'(3'b111));
    chk("fend_match", 320'({tm_a, tm_b, tm_c}), 320'(3'b111));

    // One flipped reference bit
    tag_ref[77] = ~tag_ref[77];
    step();
    chk("fend_nomatch", 320'({tm_a, tm_b, tm_c}), 320'(0));
    chk("fend_nomatch_tv", 320'(tv_a), 320'(1));

    // Drain, then backpressure across two inputs
    in_valid = 1'b0;
    step();
    chk("drain2_out_valid", 320'(ov_a), 320'(0));
    chk("drain2_tag_match", 320'(tm_a), 320'(0));
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
    st_in = mk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
    step();
    chk("bp_first", so_a, mk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4));
    st_in = mk(64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4);
    #1;
    chk("bp_in_ready", 320'(ir_a), 320'(0));
    step();
    chk("bp_hold_valid", 320'(ov_a), 320'(1));
    chk("bp_hold_state", so_a, mk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4));
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 320'(ir_a), 320'(1));
    step();
    chk("bp_second", so_a, mk(64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4));
    chk("bp_second_valid", 320'(ov_a), 320'(1));

    // Key load in the same cycle as a transfer uses the old key
    mode = 2'd1; st_in = '0; key_load = 1'b1; key_bus = K2;
    step();
    key_load = 1'b0;
    chk("kl_old_key", so_a, mk(64'd0, 64'd0, 64'd0, K1[63:0], K1[127:64]));
    step();
    chk("kl_new_key", so_a, mk(64'd0, 64'd0, 64'd0, K2[63:0], K2[127:64]));
    chk("kl_new_key_160", so_b, mk(64'd0, 64'd0, K2[63:0], K2[127:64], {32'd0, K2[159:128]}));

    // Asynchronous reset mid-stream drops the output and the key
    resetb = 1'b0;
    #1;
    chk("arst_out_valid", 320'(ov_a), 320'(0));
    chk("arst_key_valid", 320'(kv_a), 320'(0));
    chk("arst_state", so_a, 320'(0));
    resetb = 1'b1;
    #1;
    chk("arst_key_block", 320'(ir_a), 320'(0));
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
